// File: rtl/toothless_pkg.sv
// Shared types for the ALU arbiter slice: the ALU operator encoding and
// the arbiter's two-state result-holding FSM.
package toothless_pkg;

    localparam int ALU_OPCODE_BITS = 5;

    // Operator set understood by the shared ALU; any other code yields 0.
    typedef enum logic [ALU_OPCODE_BITS-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } alu_opcode_e;

    // EMPTY: no result held; FULL: result register holds a valid response.
    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters, one consumer and the
// ALU arbiter. master = requesters + consumer side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 2,
    parameter int ALU_OP_WIDTH = 5
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                   req_valid_i;
    logic [NUM_REQ-1:0]                   req_ready_o;
    logic [NUM_REQ-1:0][ALU_OP_WIDTH-1:0] req_op_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_a_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_b_i;
    logic                                 rsp_valid_o;
    logic                                 rsp_ready_i;
    logic [ID_W-1:0]                      rsp_id_o;
    logic [DATA_WIDTH-1:0]                rsp_result_o;

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o
    );

endinterface

// File: rtl/alu.sv
// Purely combinational ALU shared by all requesters of alu_arbiter.
// Shift amounts use the low $clog2(DATA_WIDTH) bits of b; unsupported
// operators produce 0.
module alu
    import toothless_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_opcode_e            op_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic [DATA_WIDTH-1:0]  b_i,
    output logic [DATA_WIDTH-1:0]  result_o
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0] shamt;

    assign shamt = b_i[SH_W-1:0];

    // Operator decode; every path assigns result_o.
    always_comb begin
        // NOTE: default assignment first so no path can infer a latch.
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = DATA_WIDTH'($signed(a_i) >>> shamt);
            ALU_SLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, with a
// single registered result slot (EMPTY/FULL). A new request is accepted
// whenever the slot is empty or is being drained in the same cycle, giving
// one-cycle latency and one result per cycle under continuous rsp_ready_i.
// Optional feature: define ALU_ARB_PERF_EN to add stall_cnt_o, a saturating
// count of cycles where some request was valid but none was granted.
module alu_arbiter
    import toothless_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 2,
    parameter int ALU_OP_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_arbiter_if.slave       bus
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       rsp_id_q;
    logic [DATA_WIDTH-1:0]  rsp_result_q;

    logic                   grant_vld;
    logic [IDX_W-1:0]       grant_idx;
    logic                   can_accept;
    logic                   fire;

    logic [ALU_OP_WIDTH-1:0] op_raw;
    alu_opcode_e            alu_op;
    logic [DATA_WIDTH-1:0]  alu_a, alu_b, alu_res;

    // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
    always_comb begin : rr_search
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!grant_vld && bus.req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // The slot can take a new result when empty or being drained this cycle;
    // reset also blocks grants because the FSM cannot capture during it.
    assign can_accept = (state_q == ARB_EMPTY) || bus.rsp_ready_i;
    assign fire       = grant_vld && can_accept && rst_n;

    // One-hot grant back to the chosen requester, zero when nothing transfers.
    always_comb begin
        bus.req_ready_o = '0;
        if (fire) begin
            bus.req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Priority pointer moves just past the winner on each grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + IDX_W'(1);
            end
        end
    end

    // Operand/operator mux from the granted requester into the shared ALU.
    always_comb begin
        op_raw = bus.req_op_i[grant_idx];
        alu_op = alu_opcode_e'(op_raw);
        alu_a  = bus.req_a_i[grant_idx];
        alu_b  = bus.req_b_i[grant_idx];
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_res)
    );

    // Result-slot FSM with registered response outputs and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_EMPTY;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rr_ptr_q <= rr_ptr_d;
            if (fire) begin
                rsp_id_q     <= grant_idx;
                rsp_result_q <= alu_res;
            end
            case (state_q)
                ARB_EMPTY: begin
                    if (fire) begin
                        state_q <= ARB_FULL;
                    end
                end
                ARB_FULL: begin
                    if (!fire && bus.rsp_ready_i) begin
                        state_q <= ARB_EMPTY;
                    end
                end
                default: state_q <= ARB_EMPTY;
            endcase
        end
    end

    assign bus.rsp_valid_o  = (state_q == ARB_FULL);
    assign bus.rsp_id_o     = rsp_id_q;
    assign bus.rsp_result_o = rsp_result_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles with pending requests but no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if ((|bus.req_valid_i) && !fire && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model of the
// arbiter (held-result flag, round-robin pointer, arithmetic ALU reference).
module tb_alu_arbiter;
    import toothless_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 2;
    localparam int OPW = 5;
    localparam int IDW = $clog2(NR);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ALU_OP_WIDTH(OPW)) bus ();

`ifdef ALU_ARB_PERF_EN
    logic [31:0] stall_cnt;
`endif

    alu_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_REQ      (NR),
        .ALU_OP_WIDTH (OPW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_ARB_PERF_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state.
    bit             m_held;
    int             m_id;
    logic [DW-1:0]  m_res;
    int             m_ptr;
    longint         m_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] alu_ref(input logic [OPW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        int            sh;
        logic [DW-1:0] ones;
        sh   = int'(b % DW);
        ones = '1;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + ~b + 1;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return (a >> sh) | (a[DW-1] ? ~(ones >> sh) : '0);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            ALU_SLTU: return (a < b) ? DW'(1) : DW'(0);
            default:  return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_held  = 1'b0;
        m_id    = 0;
        m_res   = '0;
        m_ptr   = 0;
        m_stall = 0;
    endtask

    task automatic set_req(input int idx, input logic [OPW-1:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_op_i[IDW'(idx)] = op;
        bus.req_a_i[IDW'(idx)]  = a;
        bus.req_b_i[IDW'(idx)]  = b;
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input logic [NR-1:0] valid, input logic rdy, input string tag);
        int            g;
        int            c;
        logic [NR-1:0] exp_ready;
        logic [DW-1:0] nres;
        g         = -1;
        exp_ready = '0;
        nres      = '0;
        bus.req_valid_i = valid;
        bus.rsp_ready_i = rdy;
        #1;
        if (!m_held || rdy) begin
            for (int k = 0; k < NR; k++) begin
                c = (m_ptr + k) % NR;
                if (g < 0 && valid[IDW'(c)]) g = c;
            end
        end
        if (g >= 0) exp_ready[IDW'(g)] = 1'b1;
        check({tag, ":ready"}, 64'(bus.req_ready_o), 64'(exp_ready));
        check({tag, ":rsp_valid"}, 64'(bus.rsp_valid_o), 64'(m_held));
        if (m_held) begin
            check({tag, ":rsp_id"}, 64'(bus.rsp_id_o), 64'(m_id));
            check({tag, ":rsp_result"}, 64'(bus.rsp_result_o), 64'(m_res));
        end
`ifdef ALU_ARB_PERF_EN
        check({tag, ":stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
`endif
        if (g >= 0) begin
            nres = alu_ref(bus.req_op_i[IDW'(g)], bus.req_a_i[IDW'(g)], bus.req_b_i[IDW'(g)]);
        end
        @(posedge clk);
        if (g >= 0) begin
            m_held = 1'b1;
            m_id   = g;
            m_res  = nres;
            m_ptr  = (g + 1) % NR;
        end else if (rdy) begin
            m_held = 1'b0;
        end
        if ((|valid) && g < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
        @(negedge clk);
    endtask

    initial begin
        logic [NR-1:0] rv;
        bus.req_valid_i = '0;
        bus.req_op_i    = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.rsp_ready_i = 1'b0;
        model_reset();

        // Reset state with requests pending: nothing granted, outputs zero.
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        set_req(1, ALU_ADD, 32'd2, 32'd2);
        bus.req_valid_i = 2'b11;
        bus.rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset:ready", 64'(bus.req_ready_o), 64'(0));
        check("reset:rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        check("reset:rsp_id", 64'(bus.rsp_id_o), 64'(0));
        check("reset:rsp_result", 64'(bus.rsp_result_o), 64'(0));
`ifdef ALU_ARB_PERF_EN
        check("reset:stall_cnt", 64'(stall_cnt), 64'(0));
`endif
        bus.req_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: 5 + 7 visible one cycle later.
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        step(2'b01, 1'b1, "single");
        check("single:valid", 64'(bus.rsp_valid_o), 64'(1));
        check("single:result", 64'(bus.rsp_result_o), 64'(12));
        check("single:id", 64'(bus.rsp_id_o), 64'(0));

        // Serve requester 1 so the pointer comes back to 0.
        set_req(1, ALU_SUB, 32'd100, 32'd1);
        step(2'b10, 1'b1, "align");
        check("align:result", 64'(bus.rsp_result_o), 64'(99));

        // Contention: both valid every cycle, grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            set_req(0, ALU_ADD, DW'(i), 32'd1);
            set_req(1, ALU_OR, DW'(i) << 4, 32'd1);
            step(2'b11, 1'b1, "contend");
            check("contend:id", 64'(bus.rsp_id_o), 64'(i % 2));
        end
        step(2'b00, 1'b1, "contend_drain");

        // Backpressure on requester 1's XOR result.
        set_req(1, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
        step(2'b10, 1'b1, "bp_grant");
        for (int i = 0; i < 3; i++) begin
            check("bp:held_result", 64'(bus.rsp_result_o), 64'h0000_FF00);
            step(2'b10, 1'b0, "bp_hold");
        end
        step(2'b00, 1'b1, "bp_drain");
        step(2'b00, 1'b1, "bp_empty");

        // Drain-and-refill in the same cycle.
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        step(2'b01, 1'b1, "dr_fill");
        set_req(0, ALU_SRA, 32'h8000_0000, 32'd4);
        step(2'b01, 1'b1, "dr_refill");
        check("dr:valid", 64'(bus.rsp_valid_o), 64'(1));
        check("dr:result", 64'(bus.rsp_result_o), 64'hF800_0000);
        step(2'b00, 1'b1, "dr_drain");

        // Unsupported operator returns 0 as a normal response.
        set_req(1, 5'd31, 32'd123, 32'd456);
        step(2'b10, 1'b1, "unsup");
        check("unsup:valid", 64'(bus.rsp_valid_o), 64'(1));
        check("unsup:result", 64'(bus.rsp_result_o), 64'(0));
        check("unsup:id", 64'(bus.rsp_id_o), 64'(1));
        step(2'b00, 1'b1, "unsup_drain");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < NR; r++) begin
                set_req(r, OPW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom));
            end
            rv = NR'($urandom);
            step(rv, ($urandom_range(0, 9) < 7), "rand");
        end
        step(2'b00, 1'b1, "rand_drain");

        // Reset while a result is held.
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        step(2'b01, 1'b0, "pre_rst");
        check("pre_rst:valid", 64'(bus.rsp_valid_o), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst:rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        check("mid_rst:ready", 64'(bus.req_ready_o), 64'(0));
        check("mid_rst:rsp_result", 64'(bus.rsp_result_o), 64'(0));
        check("mid_rst:rsp_id", 64'(bus.rsp_id_o), 64'(0));
        model_reset();
        bus.req_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b1, "post_rst");
        end

        // Stall accounting: FULL, consumer blocked, requester 0 waiting.
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        step(2'b01, 1'b0, "perf_fill");
        for (int i = 0; i < 10; i++) begin
            step(2'b01, 1'b0, "perf_stall");
        end
`ifdef ALU_ARB_PERF_EN
        check("perf:stall_cnt", 64'(stall_cnt), 64'(10));
`endif
        step(2'b00, 1'b1, "perf_drain");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
